// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative RV32M multiply/divide unit.
//   OP_*  : funct3 encodings of the M-extension ops.
//   state_t : controller states (IDLE -> MUL|DIV -> FIX -> DONE -> IDLE).
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_neg.sv
// muldiv_neg: conditional two's-complement negate.
//   neg  in  1      negate when high, pass through when low
//   din  in  WIDTH  value
//   dout out WIDTH  neg ? -din : din
module muldiv_neg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative RV32M multiply/divide unit feeding the register file write port.
//   clk, rst (async, active-high)
//   start/op/rs1_val/rs2_val/rd_in : request, sampled only in IDLE
//   busy                           : op in flight (accept+1 .. DONE)
//   wen/rd/rd_val                  : one-cycle write-back pulse
// Build option: define MULDIV_DIV_EN to build the divider. Without it, ops 4-7
// complete immediately with a zero result.
module muldiv #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] rs1_val,
    input  logic [W-1:0] rs2_val,
    input  logic [4:0]   rd_in,
    output logic         busy,
    output logic         wen,
    output logic [4:0]   rd,
    output logic [W-1:0] rd_val
);
    import muldiv_pkg::*;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [W-1:0]     rd_val_q, rd_val_d;
    logic [W-1:0]     a_q, a_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   prod_q, prod_d;

    // Operand sign handling for the incoming request
    logic         sgn_a, sgn_b, neg_a, neg_b;
    logic [W-1:0] a_mag, b_mag;
    logic [W:0]   mul_sum;
    logic [2*W-1:0] prod_fix;

    assign sgn_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign sgn_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign neg_a = sgn_a & rs1_val[W-1];
    assign neg_b = sgn_b & rs2_val[W-1];
    assign a_mag = neg_a ? (~rs1_val + W'(1)) : rs1_val;
    assign b_mag = neg_b ? (~rs2_val + W'(1)) : rs2_val;

    // Upper half accumulates the multiplicand; multiplier sits in the lower half and shifts out
    assign mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});

    muldiv_neg #(.WIDTH(2*W)) u_neg_prod (
        .neg  (sa_q ^ sb_q),
        .din  (prod_q),
        .dout (prod_fix)
    );

`ifdef MULDIV_DIV_EN
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic         div0_q, div0_d;
    logic         ovf;
    logic [W:0]   div_shift, div_diff;
    logic [W-1:0] quo_fix, rem_fix;

    assign ovf = sgn_b && (rs1_val == {1'b1, {(W-1){1'b0}}}) && (rs2_val == {W{1'b1}});

    assign div_shift = {rem_q, quo_q[W-1]};
    assign div_diff  = div_shift - {1'b0, b_q};

    muldiv_neg #(.WIDTH(W)) u_neg_quo (
        .neg  (sa_q ^ sb_q),
        .din  (quo_q),
        .dout (quo_fix)
    );

    muldiv_neg #(.WIDTH(W)) u_neg_rem (
        .neg  (sa_q),
        .din  (rem_q),
        .dout (rem_fix)
    );
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_val_d = rd_val_q;
        a_d      = a_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
`ifdef MULDIV_DIV_EN
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div0_d   = div0_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    rd_d   = rd_in;
                    a_d    = a_mag;
                    sa_d   = neg_a;
                    sb_d   = neg_b;
                    cnt_d  = '0;
                    prod_d = {{W{1'b0}}, b_mag};
                    if (!op[2]) begin
                        state_d = ST_MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        b_d    = b_mag;
                        quo_d  = a_mag;
                        rem_d  = '0;
                        div0_d = (rs2_val == '0);
                        if (rs2_val == '0) begin
                            // Remainder un-negates back to rs1_val in FIX
                            rem_d   = a_mag;
                            state_d = ST_FIX;
                        end else if (ovf) begin
                            // quo=|MIN|, rem=0 with matching signs already gives MIN / 0
                            state_d = ST_FIX;
                        end else begin
                            state_d = ST_DIV;
                        end
`else
                        rd_val_d = '0;
                        state_d  = ST_DONE;
`endif
                    end
                end
            end
            ST_MUL: begin
                prod_d = {mul_sum, prod_q[W-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W-1)) begin
                    state_d = ST_FIX;
                end
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                if (!div_diff[W]) begin
                    rem_d = div_diff[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = div_shift[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W-1)) begin
                    state_d = ST_FIX;
                end
            end
`endif
            ST_FIX: begin
                case (op_q)
                    OP_MUL:                        rd_val_d = prod_fix[W-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU:  rd_val_d = prod_fix[2*W-1:W];
`ifdef MULDIV_DIV_EN
                    OP_DIV, OP_DIVU:               rd_val_d = div0_q ? {W{1'b1}} : quo_fix;
                    OP_REM, OP_REMU:               rd_val_d = rem_fix;
`endif
                    default:                       rd_val_d = '0;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rd_val_q <= '0;
            a_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_val_q <= rd_val_d;
            a_q      <= a_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            div0_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div0_q <= div0_d;
        end
    end
`endif

    assign busy   = (state_q != ST_IDLE);
    assign wen    = (state_q == ST_DONE);
    assign rd     = rd_q;
    assign rd_val = rd_val_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: randomized + directed self-checking bench for muldiv (W=32).
// Expectations come from a 64-bit arithmetic reference model. Honours MULDIV_DIV_EN.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rd_in;
    logic        busy, wen;
    logic [4:0]  rd;
    logic [31:0] rd_val;

    int n_cmp = 0;
    int n_err = 0;

    muldiv #(.W(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .wen     (wen),
        .rd      (rd),
        .rd_val  (rd_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural result of an M-extension op
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int ia, ib;
        ia = a;
        ib = b;
        case (o)
            3'd0: begin ea = {32'b0, a}; eb = {32'b0, b}; end
            3'd1: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; end
            3'd2: begin ea = {{32{a[31]}}, a}; eb = {32'b0, b}; end
            default: begin ea = {32'b0, a}; eb = {32'b0, b}; end
        endcase
        p = ea * eb;
`ifdef MULDIV_DIV_EN
        case (o)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
`else
        if (o == 3'd0) return p[31:0];
        if (o < 3'd4) return p[63:32];
        return 32'h0;
`endif
    endfunction

    // Edges from the accepting edge until wen is visible
    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 3'd4) return 33;
`ifdef MULDIV_DIV_EN
        if (b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 20));
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        int k;
        logic [31:0] exp_val;
        int exp_lat;
        exp_val = ref_res(o, a, b);
        exp_lat = ref_lat(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
        k = 0;
        while (!wen && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check($sformatf("latency op%0d", o), k, exp_lat);
        check($sformatf("rd op%0d", o), rd, r);
        check($sformatf("rd_val op%0d %0h,%0h", o, a, b), rd_val, exp_val);
        @(posedge clk);
        #1;
        check("wen_one_cycle", wen, 0);
        check("busy_released", busy, 0);
    endtask

    // start held high: model acceptance from timing alone
    task automatic stress();
        int free_at, acc_e, wen_e;
        bit have;
        logic [31:0] exp_val;
        logic [4:0]  exp_rd;
        bit exp_wen, exp_busy;
        int lat;
        free_at = 0; have = 0; acc_e = 0; wen_e = 0; exp_val = 0; exp_rd = 0;
        for (int e = 0; e < 120; e++) begin
            @(negedge clk);
            start   = (e < 40);
            op      = 3'($urandom_range(0, 7));
            rs1_val = pick_val();
            rs2_val = pick_val();
            rd_in   = 5'($urandom);
            if (start && e >= free_at) begin
                lat     = ref_lat(op, rs1_val, rs2_val);
                have    = 1;
                acc_e   = e;
                wen_e   = e + lat;
                free_at = e + lat + 2;
                exp_val = ref_res(op, rs1_val, rs2_val);
                exp_rd  = rd_in;
            end
            @(posedge clk);
            #1;
            exp_wen  = have && (e == wen_e);
            exp_busy = have && (e >= acc_e) && (e <= wen_e);
            check($sformatf("stress_wen e%0d", e), wen, exp_wen);
            check($sformatf("stress_busy e%0d", e), busy, exp_busy);
            if (exp_wen) begin
                check($sformatf("stress_rd e%0d", e), rd, exp_rd);
                check($sformatf("stress_rd_val e%0d", e), rd_val, exp_val);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int wen_seen;
        rst = 1'b1; start = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_wen", wen, 0);
        check("reset_rd", rd, 0);
        check("reset_rd_val", rd_val, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        do_op(3'd5, 32'd100, 32'd7, 5'd7);
        do_op(3'd7, 32'd100, 32'd7, 5'd8);
        do_op(3'd4, 32'd5, 32'd0, 5'd9);
        do_op(3'd6, 32'd5, 32'd0, 5'd10);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        do_op(3'd0, 32'd9, 32'd9, 5'd0);
        do_op(3'd4, 32'd10, 32'd2, 5'd13);

        // Randomized single ops
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), 5'($urandom));
        end

        stress();

        // Abort mid-computation with reset
        @(negedge clk);
`ifdef MULDIV_DIV_EN
        start = 1'b1; op = 3'd4; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd17;
`else
        start = 1'b1; op = 3'd0; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd17;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_wen", wen, 0);
        check("abort_rd", rd, 0);
        check("abort_rd_val", rd_val, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wen_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (wen) wen_seen++;
        end
        check("abort_no_wen", wen_seen, 0);
        do_op(3'd0, 32'd3, 32'd4, 5'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
